// File: rtl/dest_scoreboard_pkg.sv
// rtl/dest_scoreboard_pkg.sv - shared types and constants for the destination scoreboard
// Contents: register-number width, the r0 constant, the scoreboard entry type and a
// helper that builds a stage-0 entry (register number forced to zero when not valid).
package dest_scoreboard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rnum;
  } sb_entry_t;

  // Empty slots always carry register 0 so a stale number never lingers in the pipe.
  function automatic sb_entry_t sb_entry_make(input logic v, input logic [REG_W-1:0] rnum);
    sb_entry_t e;
    e.v    = v;
    e.rnum = v ? rnum : REG_ZERO;
    return e;
  endfunction

endpackage

// File: rtl/dest_scoreboard_mux5.sv
// rtl/dest_scoreboard_mux5.sv - 2:1 mux of 5-bit register numbers (write-register select)
// Ports:
//   sel  in  1  0 selects in0, 1 selects in1
//   in0  in  5  first candidate (rt)
//   in1  in  5  second candidate (rd)
//   out  out 5  selected register number
module dest_scoreboard_mux5
  import dest_scoreboard_pkg::*;
(
  input  logic             sel,
  input  logic [REG_W-1:0] in0,
  input  logic [REG_W-1:0] in1,
  output logic [REG_W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/dest_scoreboard.sv
// rtl/dest_scoreboard.sv - destination select and in-flight write scoreboard with RAW stall
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   issue_valid                decoded instruction present this cycle
//   issue_regdst               0: dest = rt, 1: dest = rd
//   issue_regwrite             instruction writes the register file
//   issue_rs/issue_rt/issue_rd register fields of the issuing instruction
//   rs_used, rt_used           which sources the instruction actually reads
//   flush                      drop every in-flight entry
//   dst_sel, dst_reg           write-register mux select and result (combinational)
//   stall                      hold decode, insert a bubble
//   wb_valid, wb_reg           entry in the last stage (register being written back)
//   stall_count                saturating count of stalled cycles since reset
module dest_scoreboard
  import dest_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_regdst,
  input  logic             issue_regwrite,
  input  logic [REG_W-1:0] issue_rs,
  input  logic [REG_W-1:0] issue_rt,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             flush,
  output logic             dst_sel,
  output logic [REG_W-1:0] dst_reg,
  output logic             stall,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_reg,
  output logic [CNT_W-1:0] stall_count
);

  sb_entry_t        sb [DEPTH];
  logic [DEPTH-1:0] hit_rs_k;
  logic [DEPTH-1:0] hit_rt_k;
  logic             hit_rs;
  logic             hit_rt;
  logic             load_v;

  assign dst_sel = issue_regdst;

  dest_scoreboard_mux5 u_mux5 (
    .sel (issue_regdst),
    .in0 (issue_rt),
    .in1 (issue_rd),
    .out (dst_reg)
  );

  // Every stage is compared, WB included: the register file does not forward
  // a value written in the same cycle it is read.
  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign hit_rs_k[k] = sb[k].v && (sb[k].rnum == issue_rs) && (issue_rs != REG_ZERO);
    assign hit_rt_k[k] = sb[k].v && (sb[k].rnum == issue_rt) && (issue_rt != REG_ZERO);
  end

  assign hit_rs = |hit_rs_k;
  assign hit_rt = |hit_rt_k;
  assign stall  = issue_valid && ((rs_used && hit_rs) || (rt_used && hit_rt));

  // r0 writes are never tracked; a stalled instruction becomes a bubble.
  assign load_v = issue_valid && !stall && issue_regwrite && (dst_reg != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb[k] <= '0;
      end
      stall_count <= '0;
    end else begin
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          sb[k] <= '0;
        end
      end else begin
        sb[0] <= sb_entry_make(load_v, dst_reg);
        for (int k = 1; k < DEPTH; k++) begin
          sb[k] <= sb[k-1];
        end
      end
      // Stall is still live during a flush cycle, so it is counted there too.
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  assign wb_valid = sb[DEPTH-1].v;
  assign wb_reg   = sb[DEPTH-1].rnum;

endmodule
